// File: rtl/iccm_arbiter_if.sv
// Request/response bundle shared by the ICCM arbiter, its two requesters and the memory wrapper.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface iccm_arbiter_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WMASKS = 4
);

  logic                  core_req_i;
  logic [ADDR_WIDTH-1:0] core_addr_i;
  logic                  core_gnt_o;
  logic [DATA_WIDTH-1:0] core_rdata_o;
  logic                  core_rvalid_o;

  logic                  ld_req_i;
  logic                  ld_we_i;
  logic [ADDR_WIDTH-1:0] ld_addr_i;
  logic [DATA_WIDTH-1:0] ld_wdata_i;
  logic [NUM_WMASKS-1:0] ld_wmask_i;
  logic                  ld_gnt_o;
  logic [DATA_WIDTH-1:0] ld_rdata_o;
  logic                  ld_rvalid_o;

  logic                  mem_req_o;
  logic                  mem_we_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic [NUM_WMASKS-1:0] mem_wmask_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;
  logic                  mem_rvalid_i;

  modport slave (
    input  core_req_i, core_addr_i,
    output core_gnt_o, core_rdata_o, core_rvalid_o,
    input  ld_req_i, ld_we_i, ld_addr_i, ld_wdata_i, ld_wmask_i,
    output ld_gnt_o, ld_rdata_o, ld_rvalid_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
    input  mem_rdata_i, mem_rvalid_i
  );

  modport master (
    output core_req_i, core_addr_i,
    input  core_gnt_o, core_rdata_o, core_rvalid_o,
    output ld_req_i, ld_we_i, ld_addr_i, ld_wdata_i, ld_wmask_i,
    input  ld_gnt_o, ld_rdata_o, ld_rvalid_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
    output mem_rdata_i, mem_rvalid_i
  );

endinterface

// File: rtl/iccm_arbiter.sv
// Shares the single-port ICCM between core fetch and the loader, gating the core until boot
// completes and steering in-order read responses back to their issuer via an owner FIFO.
module iccm_arbiter #(
  parameter int ADDR_WIDTH      = 12,
  parameter int DATA_WIDTH      = 32,
  parameter int NUM_WMASKS      = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          boot_done_i,
  iccm_arbiter_if.slave bus,
  output logic          boot_mode_o,
  output logic          err_o
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef enum logic {
    OWNER_CORE = 1'b0,
    OWNER_LD   = 1'b1
  } owner_e;

  state_e           state_q, state_d;
  logic             last_ld_q;
  owner_e           owner_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             err_q;

  logic   pop, spurious, read_space;
  logic   core_elig, ld_elig;
  logic   core_gnt, ld_gnt;
  logic   push;
  owner_e push_owner, head_owner;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // A response arriving with nothing outstanding is dropped rather than popped.
  assign pop      = bus.mem_rvalid_i && (count_q != '0);
  assign spurious = bus.mem_rvalid_i && (count_q == '0);

  // The slot freed by this cycle's pop can be reused by this cycle's read grant.
  assign read_space = (count_q < CNT_MAX) || pop;
  assign core_elig  = bus.core_req_i && read_space;
  assign ld_elig    = bus.ld_req_i && (bus.ld_we_i || read_space);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    core_gnt = 1'b0;
    ld_gnt   = 1'b0;
    case (state_q)
      BOOT: begin
        ld_gnt = ld_elig;
        if (boot_done_i) begin
          state_d = RUN;
        end
      end
      RUN: begin
        // On contention the port that did not win last time takes this slot.
        if (core_elig && ld_elig) begin
          core_gnt = last_ld_q;
          ld_gnt   = ~last_ld_q;
        end else begin
          core_gnt = core_elig;
          ld_gnt   = ld_elig;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  assign bus.core_gnt_o = core_gnt;
  assign bus.ld_gnt_o   = ld_gnt;

  always_comb begin
    bus.mem_req_o   = 1'b0;
    bus.mem_we_o    = 1'b0;
    bus.mem_addr_o  = '0;
    bus.mem_wdata_o = '0;
    bus.mem_wmask_o = '0;
    if (core_gnt) begin
      bus.mem_req_o  = 1'b1;
      bus.mem_addr_o = bus.core_addr_i;
    end else if (ld_gnt) begin
      bus.mem_req_o   = 1'b1;
      bus.mem_we_o    = bus.ld_we_i;
      bus.mem_addr_o  = bus.ld_addr_i;
      bus.mem_wdata_o = bus.ld_wdata_i;
      bus.mem_wmask_o = bus.ld_wmask_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_ld_q <= 1'b1;
    end else if (core_gnt || ld_gnt) begin
      last_ld_q <= ld_gnt;
    end
  end

  assign push       = core_gnt || (ld_gnt && !bus.ld_we_i);
  assign push_owner = ld_gnt ? OWNER_LD : OWNER_CORE;
  assign head_owner = owner_q[rd_ptr_q];

  // Owner entries need no reset; occupancy is tracked solely by the pointers and count.
  always_ff @(posedge clk_i) begin
    if (push) begin
      owner_q[wr_ptr_q] <= push_owner;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= next_ptr(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= next_ptr(rd_ptr_q);
      end
      if (push && !pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if (spurious) begin
      err_q <= 1'b1;
    end
  end

  assign bus.core_rdata_o  = bus.mem_rdata_i;
  assign bus.ld_rdata_o    = bus.mem_rdata_i;
  assign bus.core_rvalid_o = pop && (head_owner == OWNER_CORE);
  assign bus.ld_rvalid_o   = pop && (head_owner == OWNER_LD);

  assign boot_mode_o = (state_q == BOOT);
  assign err_o       = err_q;

endmodule

// File: tb/tb_iccm_arbiter.sv
// Randomised and directed bench for iccm_arbiter: a transaction-level model predicts grants and
// memory traffic each cycle, and a monitor matches returned read data against a scoreboard queue.
module tb_iccm_arbiter;

  localparam int AW      = 12;
  localparam int DW      = 32;
  localparam int MW      = 4;
  localparam int MAX_OUT = 2;

  logic clk_i = 1'b0;
  logic rst_ni;
  logic boot_done_i;
  logic boot_mode_o;
  logic err_o;

  iccm_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASKS(MW)) bus ();

  iccm_arbiter #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .NUM_WMASKS     (MW),
    .MAX_OUTSTANDING(MAX_OUT)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .boot_done_i(boot_done_i),
    .bus        (bus),
    .boot_mode_o(boot_mode_o),
    .err_o      (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic          owner;
    logic [DW-1:0] data;
  } exp_t;

  typedef struct packed {
    int            due;
    logic [DW-1:0] data;
  } resp_t;

  int n_checks = 0;
  int n_errors = 0;
  int cycle    = 0;
  int lat_fixed;

  exp_t  sb_q[$];
  resp_t stub_q[$];
  logic  m_own_q[$];
  logic [DW-1:0] stub_mem  [0:4095];
  logic [DW-1:0] model_mem [0:4095];

  logic m_run, m_last_ld, m_err, m_gc, m_gl;
  logic last_dut_gc, last_dut_gl;

  logic          c_pend, l_pend, l_we, b_done, inject;
  logic [AW-1:0] c_addr, l_addr;
  logic [DW-1:0] l_wdata;
  logic [MW-1:0] l_mask;

  task automatic checkBit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0b, expected %0b (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic checkWord(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  function automatic logic [DW-1:0] mergeBytes(input logic [DW-1:0] old_w,
                                               input logic [DW-1:0] new_w,
                                               input logic [MW-1:0] m);
    logic [DW-1:0] r;
    r = old_w;
    for (int b = 0; b < MW; b++) begin
      if (m[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

  // Response monitor: every rvalid the DUT presents must match the oldest expected read.
  always @(negedge clk_i) begin
    exp_t e;
    if (rst_ni === 1'b1 && (bus.core_rvalid_o || bus.ld_rvalid_o)) begin
      if (bus.core_rvalid_o && bus.ld_rvalid_o) begin
        n_checks++;
        n_errors++;
        $display("[TB] FAIL both_rvalid: got core=1 ld=1, expected at most one (cycle %0d)", cycle);
      end else if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("[TB] FAIL unexpected_rvalid: got core=%0b ld=%0b, expected no response (cycle %0d)",
                 bus.core_rvalid_o, bus.ld_rvalid_o, cycle);
      end else begin
        e = sb_q.pop_front();
        checkBit("resp_owner_is_ld", bus.ld_rvalid_o, e.owner);
        checkWord("resp_data", bus.core_rvalid_o ? bus.core_rdata_o : bus.ld_rdata_o, e.data);
      end
    end
  end

  task automatic applyStimulus();
    resp_t r;
    bus.core_req_i  = c_pend;
    bus.core_addr_i = c_addr;
    bus.ld_req_i    = l_pend;
    bus.ld_we_i     = l_we;
    bus.ld_addr_i   = l_addr;
    bus.ld_wdata_i  = l_wdata;
    bus.ld_wmask_i  = l_mask;
    boot_done_i     = b_done;
    if (inject) begin
      bus.mem_rvalid_i = 1'b1;
      bus.mem_rdata_i  = $urandom;
    end else if (stub_q.size() > 0 && stub_q[0].due <= cycle) begin
      r = stub_q.pop_front();
      bus.mem_rvalid_i = 1'b1;
      bus.mem_rdata_i  = r.data;
    end else begin
      bus.mem_rvalid_i = 1'b0;
      bus.mem_rdata_i  = $urandom;
    end
  endtask

  task automatic checkOutput();
    logic pop, space, c_can, l_can, gc, gl, e_crv, e_lrv, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic [MW-1:0] e_mask;
    int due;
    pop   = bus.mem_rvalid_i && (m_own_q.size() > 0);
    space = (m_own_q.size() < MAX_OUT) || pop;
    c_can = m_run && c_pend && space;
    l_can = l_pend && (l_we || space);
    gc    = c_can && (!l_can || m_last_ld);
    gl    = l_can && !gc;
    e_crv = 1'b0;
    e_lrv = 1'b0;
    if (pop) begin
      e_crv = (m_own_q[0] == 1'b0);
      e_lrv = (m_own_q[0] == 1'b1);
    end
    e_addr  = '0;
    e_we    = 1'b0;
    e_wdata = '0;
    e_mask  = '0;
    if (gc) begin
      e_addr = c_addr;
    end else if (gl) begin
      e_addr  = l_addr;
      e_we    = l_we;
      e_wdata = l_wdata;
      e_mask  = l_mask;
    end
    checkBit("boot_mode", boot_mode_o, !m_run);
    checkBit("err", err_o, m_err);
    checkBit("core_gnt", bus.core_gnt_o, gc);
    checkBit("ld_gnt", bus.ld_gnt_o, gl);
    checkBit("mem_req", bus.mem_req_o, gc || gl);
    checkBit("mem_we", bus.mem_we_o, e_we);
    checkWord("mem_addr", 32'(bus.mem_addr_o), 32'(e_addr));
    checkWord("mem_wmask", 32'(bus.mem_wmask_o), 32'(e_mask));
    if (!gc) checkWord("mem_wdata", bus.mem_wdata_o, e_wdata);
    checkBit("core_rvalid", bus.core_rvalid_o, e_crv);
    checkBit("ld_rvalid", bus.ld_rvalid_o, e_lrv);
    last_dut_gc = bus.core_gnt_o;
    last_dut_gl = bus.ld_gnt_o;

    // The memory stub reacts to whatever the DUT actually drives.
    if (bus.mem_req_o === 1'b1) begin
      if (bus.mem_we_o === 1'b1) begin
        stub_mem[bus.mem_addr_o] = mergeBytes(stub_mem[bus.mem_addr_o], bus.mem_wdata_o, bus.mem_wmask_o);
      end else begin
        due = cycle + ((lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 3)));
        if (stub_q.size() > 0 && due <= stub_q[$].due) due = stub_q[$].due + 1;
        stub_q.push_back('{due, stub_mem[bus.mem_addr_o]});
      end
    end

    if (pop) void'(m_own_q.pop_front());
    if (gc || (gl && !l_we)) begin
      m_own_q.push_back(gl);
      sb_q.push_back('{gl, model_mem[gc ? c_addr : l_addr]});
    end
    if (gl && l_we) model_mem[l_addr] = mergeBytes(model_mem[l_addr], l_wdata, l_mask);
    if (gc || gl) m_last_ld = gl;
    if (bus.mem_rvalid_i && !pop) m_err = 1'b1;
    if (b_done) m_run = 1'b1;
    m_gc = gc;
    m_gl = gl;
  endtask

  task automatic runCycle();
    applyStimulus();
    @(negedge clk_i);
    #1;
    checkOutput();
    if (m_gc) c_pend = 1'b0;
    if (m_gl) l_pend = 1'b0;
    b_done = 1'b0;
    inject = 1'b0;
    @(posedge clk_i);
    cycle++;
    #1;
  endtask

  task automatic clearModel();
    c_pend = 1'b0;
    l_pend = 1'b0;
    b_done = 1'b0;
    inject = 1'b0;
    m_run = 1'b0;
    m_last_ld = 1'b1;
    m_err = 1'b0;
    m_own_q.delete();
    sb_q.delete();
    stub_q.delete();
  endtask

  task automatic doReset();
    rst_ni = 1'b0;
    clearModel();
    c_pend = 1'b1;
    c_addr = 12'h00F;
    applyStimulus();
    #1;
    checkBit("rst_boot_mode", boot_mode_o, 1'b1);
    checkBit("rst_err", err_o, 1'b0);
    checkBit("rst_core_gnt", bus.core_gnt_o, 1'b0);
    checkBit("rst_core_rvalid", bus.core_rvalid_o, 1'b0);
    checkBit("rst_ld_rvalid", bus.ld_rvalid_o, 1'b0);
    c_pend = 1'b0;
    @(posedge clk_i);
    cycle++;
    @(posedge clk_i);
    cycle++;
    #1;
    rst_ni = 1'b1;
  endtask

  task automatic drainAll();
    int n;
    c_pend = 1'b0;
    l_pend = 1'b0;
    n = 0;
    while ((m_own_q.size() > 0 || stub_q.size() > 0) && n < 50) begin
      runCycle();
      n++;
    end
    checkBit("drain_done", m_own_q.size() == 0, 1'b1);
    checkWord("scoreboard_empty", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int g[4];
    int n, ld_gnts, core_boot_gnts;
    for (int i = 0; i < 4096; i++) begin
      stub_mem[i]  = 32'hDEAD_0000 | i;
      model_mem[i] = 32'hDEAD_0000 | i;
    end
    lat_fixed = 1;
    c_addr = '0;
    l_addr = '0;
    l_we = 1'b0;
    l_wdata = '0;
    l_mask = '0;
    doReset();

    // Boot gating: loader writes pass while the core is held off.
    ld_gnts = 0;
    core_boot_gnts = 0;
    c_pend = 1'b1;
    c_addr = 12'h00F;
    for (int k = 0; k < 4; k++) begin
      l_pend = 1'b1;
      l_we = 1'b1;
      l_addr = AW'(k);
      l_wdata = 32'hA0 + 32'(k);
      l_mask = 4'hF;
      n = 0;
      while (l_pend && n < 10) begin
        runCycle();
        if (last_dut_gc) core_boot_gnts++;
        if (last_dut_gl) ld_gnts++;
        n++;
      end
    end
    checkWord("boot_ld_gnts", 32'(ld_gnts), 32'd4);
    checkWord("boot_core_gnts", 32'(core_boot_gnts), 32'd0);
    b_done = 1'b1;
    runCycle();
    checkBit("boot_done_cycle_core_gnt", last_dut_gc, 1'b0);
    runCycle();
    checkBit("first_run_core_gnt", last_dut_gc, 1'b1);
    checkBit("run_boot_mode", boot_mode_o, 1'b0);
    drainAll();

    // Response routing: core then loader read back image words.
    c_pend = 1'b1;
    c_addr = 12'h001;
    runCycle();
    l_pend = 1'b1;
    l_we = 1'b0;
    l_addr = 12'h002;
    l_wdata = '0;
    l_mask = '0;
    runCycle();
    drainAll();

    // Round-robin after a fresh reset: core should win the first contested cycle.
    doReset();
    b_done = 1'b1;
    runCycle();
    for (int i = 0; i < 6; i++) begin
      if (!c_pend) begin
        c_pend = 1'b1;
        c_addr = AW'(4 + i);
      end
      if (!l_pend) begin
        l_pend = 1'b1;
        l_we = 1'b0;
        l_addr = AW'(8 + i);
        l_wdata = $urandom;
        l_mask = MW'($urandom_range(0, 15));
      end
      runCycle();
      checkBit($sformatf("rr_core_gnt_%0d", i), last_dut_gc, (i % 2) == 0);
    end
    drainAll();

    // FIFO full stall with a slow memory.
    lat_fixed = 3;
    for (int k = 0; k < 4; k++) begin
      c_pend = 1'b1;
      c_addr = AW'(k);
      n = 0;
      while (c_pend && n < 20) begin
        runCycle();
        n++;
      end
      g[k] = cycle - 1;
    end
    checkWord("stall_g1_gap", 32'(g[1] - g[0]), 32'd1);
    checkWord("stall_g2_gap", 32'(g[2] - g[0]), 32'd3);
    checkWord("stall_g3_gap", 32'(g[3] - g[0]), 32'd4);
    drainAll();

    // Asynchronous reset with two reads in flight.
    c_pend = 1'b1;
    c_addr = 12'h001;
    runCycle();
    c_pend = 1'b1;
    c_addr = 12'h002;
    runCycle();
    checkWord("midrst_outstanding", 32'(m_own_q.size()), 32'd2);
    c_pend = 1'b1;
    c_addr = 12'h003;
    applyStimulus();
    #1;
    rst_ni = 1'b0;
    #1;
    checkBit("midrst_boot_mode", boot_mode_o, 1'b1);
    checkBit("midrst_core_gnt", bus.core_gnt_o, 1'b0);
    bus.mem_rvalid_i = 1'b1;
    #1;
    checkBit("midrst_core_rvalid", bus.core_rvalid_o, 1'b0);
    checkBit("midrst_ld_rvalid", bus.ld_rvalid_o, 1'b0);
    checkBit("midrst_err", err_o, 1'b0);
    clearModel();
    bus.mem_rvalid_i = 1'b0;
    @(posedge clk_i);
    cycle++;
    #1;
    rst_ni = 1'b1;

    // Spurious response straight after reset.
    inject = 1'b1;
    runCycle();
    checkBit("spurious_err_set", err_o, 1'b1);
    for (int i = 0; i < 3; i++) runCycle();
    doReset();

    // Randomised traffic with variable memory latency.
    lat_fixed = 0;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 15) == 0) b_done = 1'b1;
      if (!c_pend && $urandom_range(0, 2) != 0) begin
        c_pend = 1'b1;
        c_addr = AW'($urandom_range(0, 15));
      end
      if (!l_pend && $urandom_range(0, 2) != 0) begin
        l_pend = 1'b1;
        l_we = 1'($urandom_range(0, 1));
        l_addr = AW'($urandom_range(0, 15));
        l_wdata = $urandom;
        l_mask = MW'($urandom_range(0, 15));
      end
      runCycle();
    end
    drainAll();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
